// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel divider, sync/blank flags and start pulses
// Ports: i_clk system clock; i_reset async active-high reset; i_en run enable (low holds origin);
//        o_hsync/o_vsync registered syncs; o_video_on/o_hblank/o_vblank registered area flags;
//        o_p_tick pixel enable; o_line_start/o_frame_start wrap pulses; o_pixel_x/o_pixel_y counts
module vga_timing_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   CNT_W     = 10,
    parameter int   CLK_DIV   = 2,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_video_on,
    output logic             o_hblank,
    output logic             o_vblank,
    output logic             o_p_tick,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic [CNT_W-1:0] o_pixel_x,
    output logic [CNT_W-1:0] o_pixel_y
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] r_div, w_div_nx;
    logic [CNT_W-1:0] r_h, r_v, w_h_nx, w_v_nx;
    logic             r_hs, r_vs, r_vid, r_hb, r_vb, r_ls, r_fs;
    logic             w_tick, w_h_wrap, w_v_wrap;

    // Flags are decoded from the next-state counts so they land in the same clk as the counts.
    always_comb begin
        w_tick   = i_en && !i_reset && r_div == DIV_LAST;
        w_h_wrap = w_tick && r_h == H_LAST;
        w_v_wrap = w_h_wrap && r_v == V_LAST;
        w_div_nx = (!i_en || r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        w_h_nx   = (!i_en || w_h_wrap) ? '0 : w_tick ? r_h + 1'b1 : r_h;
        w_v_nx   = (!i_en || w_v_wrap) ? '0 : w_h_wrap ? r_v + 1'b1 : r_v;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
            r_vid <= 1'b0;
            r_hb  <= 1'b0;
            r_vb  <= 1'b0;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_div <= w_div_nx;
            r_h   <= w_h_nx;
            r_v   <= w_v_nx;
            r_hs  <= (i_en && w_h_nx >= HS_BEG && w_h_nx <= HS_END) ? HS_POL : ~HS_POL;
            r_vs  <= (i_en && w_v_nx >= VS_BEG && w_v_nx <= VS_END) ? VS_POL : ~VS_POL;
            r_vid <= i_en && w_h_nx < H_VIS && w_v_nx < V_VIS;
            r_hb  <= i_en && w_h_nx >= H_VIS;
            r_vb  <= i_en && w_v_nx >= V_VIS;
            r_ls  <= w_h_wrap;
            r_fs  <= w_v_wrap;
        end
    end

    assign o_hsync       = r_hs;
    assign o_vsync       = r_vs;
    assign o_video_on    = r_vid;
    assign o_hblank      = r_hb;
    assign o_vblank      = r_vb;
    assign o_p_tick      = w_tick;
    assign o_line_start  = r_ls;
    assign o_frame_start = r_fs;
    assign o_pixel_x     = r_h;
    assign o_pixel_y     = r_v;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA display path. It generalises the fixed 640x480 synchroniser: all horizontal and vertical intervals, the pixel-clock divide ratio and the sync polarities are parameters. Adds a run enable, registered line/frame start pulses and blanking flags. Outputs are cycle-aligned with the pixel coordinates. It sits between the system clock and the pixel/graphics generators, which consume `pixel_x`, `pixel_y`, `video_on` and `p_tick`.

## Interface
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch (pixels after display)
- `H_SYNC`, 96: horizontal sync width
- `H_BACK`, 48: horizontal back porch
- `V_DISPLAY`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vertical sync width
- `V_BACK`, 33: vertical back porch
- `CNT_W`, 10: counter width; must hold H_TOTAL-1 and V_TOTAL-1
- `CLK_DIV`, 2: clk cycles per pixel (>=1)
- `HS_POL`, 1'b0: hsync level while asserted
- `VS_POL`, 1'b0: vsync level while asserted
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  run enable; low holds the raster at origin
- `hsync`  out  1  horizontal sync, registered
- `vsync`  out  1  vertical sync, registered
- `video_on`  out  1  high while (pixel_x, pixel_y) is in the display area
- `hblank`  out  1  high while pixel_x >= H_DISPLAY
- `vblank`  out  1  high while pixel_y >= V_DISPLAY
- `p_tick`  out  1  pixel enable, one clk wide every CLK_DIV clks
- `line_start`  out  1  one-clk pulse when pixel_x wraps to 0
- `frame_start`  out  1  one-clk pulse when both counters wrap to 0
- `pixel_x`  out  CNT_W  horizontal count
- `pixel_y`  out  CNT_W  vertical count

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Interval order: display, front porch, sync, back porch.
- Divider `div` counts 0..CLK_DIV-1. `p_tick = en && div==CLK_DIV-1`. For CLK_DIV=1, `p_tick = en`.
- On a p_tick clk:
  - h increments, or wraps to 0 at H_TOTAL-1.
  - On h wrap, v increments, or wraps to 0 at V_TOTAL-1.
- h and v drive `pixel_x` and `pixel_y` directly.
- hsync asserted (= HS_POL) for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; defaults 656..751. Otherwise ~HS_POL.
- vsync asserted (= VS_POL) for v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]; defaults 490..491.
- hsync, vsync, video_on, hblank and vblank are registered, decoded from the next-state h/v. They change in the same clk as pixel_x/pixel_y, with zero skew and no glitches.
- line_start and frame_start are registered, set from the wrap condition. They are high in the first clk where the new pixel_x=0 (and pixel_y=0 for frame_start) is presented.
- `en` low (synchronous):
  - next clk forces div=0, h=0, v=0;
  - sync outputs go inactive; video_on, start pulses and p_tick go 0.
- `en` rising: counting resumes from the origin. First p_tick comes CLK_DIV clks after the first clk with en=1. No start pulses are issued until the first wrap.
- Arithmetic is unsigned. Comparisons use CNT_W-bit counts. The divider width is max(1, clog2(CLK_DIV)).

## Timing
- Reset (async, immediate):
  - div=0, pixel_x=0, pixel_y=0;
  - hsync=~HS_POL, vsync=~VS_POL;
  - video_on=0, hblank=0, vblank=0, line_start=0, frame_start=0, p_tick=0.
- First clk after reset release with en=1: video_on=1. Flag latency from count change is 0 clks.
- Line period is H_TOTAL*CLK_DIV clks (default 1600). Frame period is V_TOTAL line periods (default 840000 clks).
- Simultaneous h and v wrap: line_start and frame_start pulse in the same clk.
- Reset or en low mid-frame: no partial-line pulse. The raster restarts at (0,0).

## Test plan
- Reset asserted mid-frame, then en=1 -> all outputs at their reset values immediately. video_on=1 one clk after release. pixel_x=1 after 2 clks (CLK_DIV=2).
- Defaults, run one line -> p_tick every 2nd clk; hsync low exactly while pixel_x=656..751 (192 clks); line_start once per 1600 clks; video_on falls when pixel_x=640.
- Defaults, run two frames -> vsync low for lines 490..491; vblank for lines 480..524; frame_start exactly every 840000 clks, coincident with line_start.
- CLK_DIV=1, H=8/2/2/2, V=4/1/1/1, HS_POL=VS_POL=1 -> p_tick constant 1; hsync high at x=10..11; vsync high at y=5; H_TOTAL=14, frame=98 clks.
- en dropped at pixel_x=300, pixel_y=200, held 5 clks, raised -> next clk counts=0, sync inactive, video_on=0; after rise, no start pulses until the first wrap; hsync again at x=656.
